// File: rtl/alu_ctrl_pkg.sv
// Shared ALU encodings: ALU_sel operation codes, ALUOP classes and supported R-type Funct values.
// Used by the main control, this decoder and the ALU so all three agree on one set of constants.
package alu_ctrl_pkg;

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_XOR = 4'b0011;
  localparam logic [3:0] SEL_SLL = 4'b0100;
  localparam logic [3:0] SEL_SRL = 4'b0101;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SLT = 4'b0111;
  localparam logic [3:0] SEL_SRA = 4'b1000;
  localparam logic [3:0] SEL_LUI = 4'b1001;
  localparam logic [3:0] SEL_NOR = 4'b1100;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_AND   = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_XOR   = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_LUI   = 3'b110;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  localparam logic [5:0] FUNCT_SLL = 6'd0;
  localparam logic [5:0] FUNCT_SRL = 6'd2;
  localparam logic [5:0] FUNCT_SRA = 6'd3;
  localparam logic [5:0] FUNCT_ADD = 6'd32;
  localparam logic [5:0] FUNCT_SUB = 6'd34;
  localparam logic [5:0] FUNCT_AND = 6'd36;
  localparam logic [5:0] FUNCT_OR  = 6'd37;
  localparam logic [5:0] FUNCT_XOR = 6'd38;
  localparam logic [5:0] FUNCT_NOR = 6'd39;
  localparam logic [5:0] FUNCT_SLT = 6'd42;

  typedef struct packed {
    logic [3:0] sel;
    logic       illegal;
  } decode_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational R-type Funct -> {sel, illegal}; zero latency, no handshake.
// Unknown or unsupported Funct falls into the default arm, yielding ADD with illegal set.
module alu_funct_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output decode_t    dec
);

  always_comb begin
    dec.sel     = SEL_ADD;
    dec.illegal = 1'b0;
    case (funct)
      FUNCT_SLL: dec.sel = SEL_SLL;
      FUNCT_SRL: dec.sel = SEL_SRL;
      FUNCT_SRA: dec.sel = SEL_SRA;
      FUNCT_ADD: dec.sel = SEL_ADD;
      FUNCT_SUB: dec.sel = SEL_SUB;
      FUNCT_AND: dec.sel = SEL_AND;
      FUNCT_OR:  dec.sel = SEL_OR;
      FUNCT_XOR: dec.sel = SEL_XOR;
      FUNCT_NOR: dec.sel = SEL_NOR;
      FUNCT_SLT: dec.sel = SEL_SLT;
      default:   dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// ALUOP/Funct -> registered ALU_sel plus illegal-Funct flag.
// One clock of latency; no backpressure, a fresh decode is loaded every cycle.
module alu_control
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ALUOP,
  input  logic [5:0] Funct,
  output logic [3:0] ALU_sel,
  output logic       illegal_funct
);

  decode_t funct_dec;
  decode_t nxt;

  alu_funct_decode u_funct_decode (
    .funct (Funct),
    .dec   (funct_dec)
  );

  // An ALUOP with X/Z bits matches no arm, so it lands in the default as illegal.
  always_comb begin
    nxt.sel     = SEL_ADD;
    nxt.illegal = 1'b0;
    case (ALUOP)
      ALUOP_ADD:   nxt.sel = SEL_ADD;
      ALUOP_SUB:   nxt.sel = SEL_SUB;
      ALUOP_AND:   nxt.sel = SEL_AND;
      ALUOP_OR:    nxt.sel = SEL_OR;
      ALUOP_XOR:   nxt.sel = SEL_XOR;
      ALUOP_SLT:   nxt.sel = SEL_SLT;
      ALUOP_LUI:   nxt.sel = SEL_LUI;
      ALUOP_RTYPE: nxt     = funct_dec;
      default:     nxt.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_sel       <= SEL_ADD;
      illegal_funct <= 1'b0;
    end else begin
      ALU_sel       <= nxt.sel;
      illegal_funct <= nxt.illegal;
    end
  end

endmodule

// File: tb/tb_alu_control.sv
// Directed bench for alu_control: table-driven reference model checked every cycle,
// plus literal expectations for reset, each decode and the async reset path.
module tb_alu_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] ALUOP;
  logic [5:0] Funct;
  logic [3:0] ALU_sel;
  logic       illegal_funct;

  int checks = 0;
  int fails  = 0;

  alu_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ALUOP         (ALUOP),
    .Funct         (Funct),
    .ALU_sel       (ALU_sel),
    .illegal_funct (illegal_funct)
  );

  always #5 clk = ~clk;

  // Reference tables written straight from the opcode listings.
  logic [3:0] class_sel [0:7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                                  4'b0011, 4'b0111, 4'b1001, 4'b0000};
  logic [5:0] funct_val [0:9] = '{6'd0, 6'd2, 6'd3, 6'd32, 6'd34,
                                  6'd36, 6'd37, 6'd38, 6'd39, 6'd42};
  logic [3:0] funct_sel [0:9] = '{4'b0100, 4'b0101, 4'b1000, 4'b0010, 4'b0110,
                                  4'b0000, 4'b0001, 4'b0011, 4'b1100, 4'b0111};

  function automatic logic [4:0] model_decode(input logic [2:0] op, input logic [5:0] f);
    if ($isunknown(op)) return {4'b0010, 1'b1};
    if (op != 3'b111) return {class_sel[op], 1'b0};
    if (!$isunknown(f))
      for (int i = 0; i < 10; i++)
        if (f == funct_val[i]) return {funct_sel[i], 1'b0};
    return {4'b0010, 1'b1};
  endfunction

  // Expected outputs: what was decoded at the last edge, or reset values.
  logic [4:0] exp_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= {4'b0010, 1'b0};
    else        exp_q <= model_decode(ALUOP, Funct);
  end

  logic model_on = 1'b0;
  always @(negedge clk) begin
    if (model_on) begin
      checks++;
      if ($isunknown({ALU_sel, illegal_funct}) || {ALU_sel, illegal_funct} !== exp_q) begin
        fails++;
        $display("FAIL model_cmp t=%0t: got sel=%b ill=%b, expected sel=%b ill=%b",
                 $time, ALU_sel, illegal_funct, exp_q[4:1], exp_q[0]);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] esel, input logic eill);
    checks++;
    if (ALU_sel !== esel || illegal_funct !== eill) begin
      fails++;
      $display("FAIL %s: got sel=%b ill=%b, expected sel=%b ill=%b",
               name, ALU_sel, illegal_funct, esel, eill);
    end
  endtask

  // Drive just after an edge, then sample between the following two edges.
  task automatic drive(input logic [2:0] op, input logic [5:0] f);
    @(posedge clk);
    #2;
    ALUOP = op;
    Funct = f;
  endtask

  task automatic apply_chk(input string name, input logic [2:0] op, input logic [5:0] f,
                           input logic [3:0] esel, input logic eill);
    drive(op, f);
    @(posedge clk);
    @(negedge clk);
    chk(name, esel, eill);
  endtask

  // Hand-computed directed vectors.
  logic [3:0] op_exp  [0:6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1001};
  logic [5:0] rf_val  [0:9] = '{6'd0, 6'd2, 6'd3, 6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42};
  logic [3:0] rf_exp  [0:9] = '{4'b0100, 4'b0101, 4'b1000, 4'b0010, 4'b0110,
                                4'b0000, 4'b0001, 4'b0011, 4'b1100, 4'b0111};

  initial begin
    rst_n = 1'b1;
    ALUOP = 3'b111;
    Funct = 6'd33;
    #1 rst_n = 1'b0;
    #1 chk("reset_async", 4'b0010, 1'b0);
    model_on = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      apply_chk($sformatf("aluop_%0d", i), 3'(i), 6'bx, op_exp[i], 1'b0);

    for (int i = 0; i < 10; i++)
      apply_chk($sformatf("funct_%0d", rf_val[i]), 3'b111, rf_val[i], rf_exp[i], 1'b0);

    apply_chk("funct_33_illegal", 3'b111, 6'd33, 4'b0010, 1'b1);
    apply_chk("funct_63_illegal", 3'b111, 6'd63, 4'b0010, 1'b1);
    apply_chk("funct_34_after_illegal", 3'b111, 6'd34, 4'b0110, 1'b0);
    apply_chk("aluop_ori_funct_bad", 3'b011, 6'd33, 4'b0001, 1'b0);

    // Unknown Funct under R-type: the model covers both 2- and 4-state semantics.
    drive(3'b111, 6'bx);
    drive(3'b111, 6'd34);
    @(posedge clk);
    @(negedge clk);
    chk("funct_x_then_34", 4'b0110, 1'b0);

    // Back-to-back changes every cycle.
    drive(3'b111, 6'd39);
    drive(3'b000, 6'd0);
    drive(3'b111, 6'd1);
    drive(3'b101, 6'd42);
    drive(3'b111, 6'd3);
    drive(3'b110, 6'd2);
    @(negedge clk);
    chk("b2b_sra", 4'b1000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_lui", 4'b1001, 1'b0);

    // Asynchronous reset asserted between edges while ALUOP selects SUB.
    apply_chk("pre_reset_sub", 3'b001, 6'd0, 4'b0110, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("mid_cycle_reset", 4'b0010, 1'b0);
    @(posedge clk);
    #1 chk("held_in_reset", 4'b0010, 1'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("released_before_edge", 4'b0010, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("sub_after_release", 4'b0110, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    model_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
